// File: rtl/fp_acc_sched_pkg.sv
// Shared definitions for the streaming FP32 group accumulator.
package fp_acc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REDUCE = 2'd2
    } accState_e;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    localparam int DEFAULT_STAGES = 7;

endpackage

// File: rtl/fp_acc_sched_nop_pipeline.sv
// Shift register of "no operation" flags that travels alongside the
// external adder, so each adder result is known to be live or empty.
module NOPPipeline #(
    parameter int Stages = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic NOPIn,
    output logic NOPOut
);

    logic [Stages-1:0] nop_q;

    // Shift the flags one stage per cycle; after reset every slot is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nop_q <= '1;
        end else begin
            nop_q <= {nop_q[Stages-2:0], NOPIn};
        end
    end

    assign NOPOut = nop_q[Stages-1];

endmodule

// File: rtl/fp_acc_sched.sv
// Group accumulator that time-shares one external pipelined FP32 adder.
// Partial sums circulate through the adder; a tag pipeline marks which
// adder outputs carry live data, and one hold register pairs them up
// during the final reduction.
module fp_acc_sched
    import fp_acc_sched_pkg::*;
#(
    parameter int DataWidth       = 32,
    parameter int Pipeline_Stages = DEFAULT_STAGES,
    parameter int LenWidth        = 16,
    parameter int LiveWidth       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LenWidth-1:0]  cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] DataIn,
    output logic [DataWidth-1:0] add_a,
    output logic [DataWidth-1:0] add_b,
    input  logic [DataWidth-1:0] add_res,
    output logic                 DataOutValid,
    output logic [DataWidth-1:0] DataOut,
    output logic                 busy
);

    accState_e              state_q, state_d;
    logic [LenWidth-1:0]    len_q, len_d;
    logic [LenWidth-1:0]    cnt_q, cnt_d;
    logic [LiveWidth-1:0]   live_q, live_d;
    logic [DataWidth-1:0]   hold_q, hold_d;
    logic                   holdFull_q, holdFull_d;
    logic [DataWidth-1:0]   dataOut_q, dataOut_d;
    logic                   dataOutValid_q, dataOutValid_d;

    logic                   accept;
    logic                   issueValid;
    logic                   ret;
    logic                   nopOut;
    logic [DataWidth-1:0]   opA, opB;

    NOPPipeline #(
        .Stages (Pipeline_Stages)
    ) u_tagPipe (
        .clk    (clk),
        .rst    (rst),
        .NOPIn  (~issueValid),
        .NOPOut (nopOut)
    );

    assign ret          = ~nopOut;
    assign in_ready     = ~rst && (state_q != REDUCE);
    assign accept       = in_valid && in_ready;
    assign add_a        = opA;
    assign add_b        = opB;
    assign DataOut      = dataOut_q;
    assign DataOutValid = dataOutValid_q;
    assign busy         = (state_q != IDLE);

    // Next-state logic: input issue while collecting, pairwise folding of returning sums while reducing.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        live_d         = live_q;
        hold_d         = hold_q;
        holdFull_d     = holdFull_q;
        dataOut_d      = dataOut_q;
        dataOutValid_d = 1'b0;
        opA            = DataWidth'(ZERO);
        opB            = DataWidth'(ZERO);
        issueValid     = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                opA        = accept ? DataIn : DataWidth'(ZERO);
                opB        = ret ? add_res : DataWidth'(ZERO);
                issueValid = accept || ret;
                if (accept) begin
                    if (state_q == IDLE) begin
                        len_d   = (cfg_len == '0) ? LenWidth'(1) : cfg_len;
                        cnt_d   = LenWidth'(1);
                        live_d  = LiveWidth'(1);
                        state_d = (len_d == LenWidth'(1)) ? REDUCE : ACCUM;
                    end else begin
                        cnt_d = cnt_q + LenWidth'(1);
                        if (!ret) begin
                            live_d = live_q + LiveWidth'(1);
                        end
                        if (cnt_d == len_q) begin
                            state_d = REDUCE;
                        end
                    end
                end
            end
            REDUCE: begin
                if (ret) begin
                    if (holdFull_q) begin
                        opA        = hold_q;
                        opB        = add_res;
                        issueValid = 1'b1;
                        holdFull_d = 1'b0;
                        live_d     = live_q - LiveWidth'(1);
                    end else if (live_q > LiveWidth'(1)) begin
                        hold_d     = add_res;
                        holdFull_d = 1'b1;
                    end else begin
                        dataOut_d      = add_res;
                        dataOutValid_d = 1'b1;
                        live_d         = '0;
                        state_d        = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register the controller state; reset drops any group in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            live_q         <= '0;
            hold_q         <= '0;
            holdFull_q     <= 1'b0;
            dataOut_q      <= '0;
            dataOutValid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            live_q         <= live_d;
            hold_q         <= hold_d;
            holdFull_q     <= holdFull_d;
            dataOut_q      <= dataOut_d;
            dataOutValid_q <= dataOutValid_d;
        end
    end

endmodule

// File: tb/tb_fp_acc_sched.sv
// Self-checking bench for fp_acc_sched with a behavioural FP32 adder and
// a group-sum reference model.
module tb_fp_acc_sched;

    localparam int L         = 7;
    localparam int LAT_BOUND = ($clog2(L) + 1) * L + 1;

    typedef struct {
        logic [31:0] sum;
        int          len;
        int          closeCycle;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] DataIn = '0;
    logic [31:0] add_a, add_b, add_res;
    logic        DataOutValid;
    logic [31:0] DataOut;
    logic        busy;

    int          errorCount = 0;
    int          checkCount = 0;
    int          cycle = 0;
    bit          groupOpen = 0;
    bit          reducing = 0;
    int          grpLen = 0;
    int          grpCount = 0;
    real         grpSum = 0.0;
    logic [31:0] expectedOut = '0;
    logic [31:0] vals [64];
    grp_t        expQ [$];
    logic [31:0] addPipe [L];

    fp_acc_sched #(
        .DataWidth       (32),
        .Pipeline_Stages (L),
        .LenWidth        (16),
        .LiveWidth       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_len      (cfg_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .DataIn       (DataIn),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_res      (add_res),
        .DataOutValid (DataOutValid),
        .DataOut      (DataOut),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int e);
        real p = 1.0;
        if (e >= 0) repeat (e) p = p * 2.0;
        else        repeat (-e) p = p / 2.0;
        return p;
    endfunction

    function automatic real fp32ToReal(input logic [31:0] b);
        real m;
        if (b[30:23] == 8'd0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] realToFp32(input real r);
        real    a;
        int     e;
        longint man;
        logic   s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        man = longint'((a - 1.0) * 8388608.0);
        return {s, 8'(e), 23'(man)};
    endfunction

    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        return realToFp32(fp32ToReal(a) + fp32ToReal(b));
    endfunction

    // External L-stage adder, cleared together with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) addPipe[i] <= '0;
        end else begin
            addPipe[0] <= fpAdd(add_a, add_b);
            for (int i = 1; i < L; i++) addPipe[i] <= addPipe[i-1];
        end
    end

    assign add_res = addPipe[L-1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic modelAccept(input logic [31:0] data, input logic [15:0] len);
        if (!groupOpen) begin
            groupOpen = 1;
            grpLen    = (len == 16'd0) ? 1 : int'(len);
            grpCount  = 0;
            grpSum    = 0.0;
        end
        grpSum = grpSum + fp32ToReal(data);
        grpCount++;
        if (grpCount == grpLen) begin
            expQ.push_back('{realToFp32(grpSum), grpLen, cycle});
            groupOpen = 0;
            reducing  = 1;
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [31:0] data,
                                 input logic [15:0] len, output bit accepted);
        grp_t g;
        int   lat;
        @(negedge clk);
        cycle++;
        if (DataOutValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPulse", 32'(DataOutValid), 32'd0);
            end else begin
                g = expQ.pop_front();
                checkOutput("groupSum", DataOut, g.sum);
                lat = cycle - g.closeCycle;
                if (g.len == 1) checkOutput("latencyLen1", 32'(lat), 32'(L + 1));
                else            checkOutput("latencyBound", 32'(lat <= LAT_BOUND), 32'd1);
                expectedOut = g.sum;
                reducing    = 0;
            end
        end else begin
            checkOutput("dataOutHold", DataOut, expectedOut);
        end
        checkOutput("inReady", 32'(in_ready), 32'(!reducing));
        checkOutput("busy", 32'(busy), 32'(groupOpen || reducing));
        in_valid = valid;
        DataIn   = data;
        cfg_len  = len;
        accepted = valid && in_ready;
        if (accepted) modelAccept(data, len);
    endtask

    task automatic sendGroup(input int count, input logic [15:0] cfg, input int gapLo, input int gapHi);
        for (int i = 0; i < count; i++) begin
            int          gap;
            int          tries;
            bit          acc;
            logic [15:0] c;
            gap = (gapHi > gapLo) ? int'($urandom_range(gapHi, gapLo)) : gapLo;
            c   = (i == 0) ? cfg : 16'($urandom);
            repeat (gap) applyStimulus(1'b0, 32'h0, c, acc);
            acc   = 0;
            tries = 0;
            while (!acc && tries < 100) begin
                applyStimulus(1'b1, vals[i], c, acc);
                tries++;
            end
            checkOutput("acceptWait", 32'(acc), 32'd1);
        end
    endtask

    task automatic waitIdle();
        bit acc;
        for (int i = 0; i < 200 && (groupOpen || reducing); i++)
            applyStimulus(1'b0, 32'h0, 16'($urandom), acc);
        checkOutput("drain", 32'(groupOpen || reducing), 32'd0);
        repeat (3) applyStimulus(1'b0, 32'h0, 16'($urandom), acc);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        expQ.delete();
        groupOpen   = 0;
        reducing    = 0;
        expectedOut = '0;
        #1;
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstOutValid", 32'(DataOutValid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDataOut", DataOut, 32'h0);
        checkOutput("rstAddA", add_a, 32'h0);
        checkOutput("rstAddB", add_b, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("releaseInReady", 32'(in_ready), 32'd1);
    endtask

    task automatic fillConst(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) vals[i] = v;
    endtask

    initial begin
        bit acc;
        doReset();

        // Single input
        fillConst(1, 32'h3FC0_0000);
        sendGroup(1, 16'd1, 0, 0);
        waitIdle();

        // Short group 1.0 .. 4.0
        for (int i = 0; i < 4; i++) vals[i] = realToFp32(real'(i + 1));
        sendGroup(4, 16'd4, 0, 0);
        waitIdle();

        // Long group of sixteen 1.0
        fillConst(16, 32'h3F80_0000);
        sendGroup(16, 16'd16, 0, 0);
        waitIdle();

        // Gappy input, in_valid toggling
        fillConst(8, 32'h4000_0000);
        sendGroup(8, 16'd8, 1, 1);
        waitIdle();

        // Back-to-back groups with cfg_len scrambled mid-group
        fillConst(5, 32'h3F80_0000);
        sendGroup(3, 16'd3, 0, 0);
        sendGroup(5, 16'd5, 0, 0);
        waitIdle();

        // Length zero behaves as one
        fillConst(1, 32'h4040_0000);
        sendGroup(1, 16'd0, 0, 0);
        waitIdle();

        // Reset during the reduction of a long group
        fillConst(16, 32'h3F80_0000);
        sendGroup(16, 16'd16, 0, 0);
        repeat (10) applyStimulus(1'b0, 32'h0, 16'd0, acc);
        doReset();
        fillConst(4, 32'h3F80_0000);
        sendGroup(4, 16'd4, 0, 0);
        waitIdle();

        // Randomized groups with exactly representable half-integer values
        for (int g = 0; g < 30; g++) begin
            int cfg;
            int cnt;
            cfg = int'($urandom_range(20, 0));
            cnt = (cfg == 0) ? 1 : cfg;
            for (int i = 0; i < cnt; i++)
                vals[i] = realToFp32(real'(int'($urandom_range(32, 0)) - 16) * 0.5);
            sendGroup(cnt, 16'(cfg), 0, int'($urandom_range(2, 0)));
            if ($urandom_range(1, 0) == 1) waitIdle();
        end
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fp_acc_sched.md
Name: fp_acc_sched

Overview:
- Controller that time-shares one external L-stage pipelined FP32 adder (FP_ADD, aclr tied to rst) to sum groups of streaming FP32 values.
- Accepts one input per cycle with no adder-latency stalls: partial sums circulate inside the adder pipeline, tracked by a 1-bit tag pipeline.
- When a group's last input has been issued, the circulating partial sums are reduced to one result, emitted as a one-cycle pulse.
- Sits between the upstream data source and the downstream result consumer, in place of a fixed-count accumulator.

Parameters:
- DataWidth, 32, operand/result width (FP32).
- Pipeline_Stages, 7, adder latency L: operands at cycle t give add_res at cycle t+L.
- LenWidth, 16, width of the group-length configuration.
- LiveWidth, 4, width of the live partial-sum counter; must satisfy 2^LiveWidth > Pipeline_Stages.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- cfg_len, input, LenWidth, number of inputs per group; sampled when a group's first input is accepted.
- in_valid, input, 1, DataIn valid.
- in_ready, output, 1, block accepts DataIn this cycle.
- DataIn, input, DataWidth, FP32 input value.
- add_a, output, DataWidth, adder operand A.
- add_b, output, DataWidth, adder operand B.
- add_res, input, DataWidth, adder result, L cycles after its operands.
- DataOutValid, output, 1, one-cycle pulse: DataOut holds a group sum.
- DataOut, output, DataWidth, group sum (registered).
- busy, output, 1, high while a group is in progress (state != IDLE).

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after release.
  - DataOutValid=0, DataOut=0, busy=0, add_a=add_b=0.
  - Tag pipeline all 0, live=0, hold empty, state IDLE.
- Reset mid-operation: the group is discarded; no DataOutValid for it.
- Tag pipeline: an L-deep shift of the issue-valid bit; ret = tag at stage L, aligned with add_res.
- Issue rule, every cycle: a = accepted input, else 0; b = add_res if ret, else 0. Tag in = (accepted OR ret).
- States:
  - IDLE: in_ready=1.
    - On accept: len_q=cfg_len (0 treated as 1), cnt=1, live=1.
    - Go to REDUCE if len_q==1, else ACCUM.
  - ACCUM: in_ready=1; cnt increments on each accept.
    - Accept with no ret: live+1 (new chain).
    - Accept with ret: live unchanged.
    - ret with no accept: the partial sum recirculates (+0); live unchanged.
    - When the accept makes cnt==len_q, go to REDUCE next cycle.
  - REDUCE: in_ready=0.
    - ret with hold empty and live>1: capture add_res into hold; no issue.
    - ret with hold full: issue add(hold, add_res); hold empties; live-1.
    - ret with hold empty and live==1: this is the final sum. Next cycle DataOut=add_res, DataOutValid=1, state IDLE, live=0.
    - No ret: no issue (tag 0).
- live counts in-flight plus held partial sums and never exceeds min(len_q, L).
- DataOutValid has no backpressure. DataOut holds its value until the next emit.
- Latency, len=1: accept at cycle 0, DataOutValid at cycle L+1.
- Latency, general: the final emit follows the last accept within (ceil(log2 L)+1)*L+1 cycles.
- in_valid gaps in ACCUM are legal; circulating sums stay intact.
- Summation order is implementation-defined (FP non-associative); verification uses exactly representable values.
- cnt wrap is impossible: cnt ≤ len_q.
- Issue and capture in the same cycle never occur for the same ret.

Decomposition:
- Shared package:
  - State encoding IDLE/ACCUM/REDUCE.
  - FP32 constant ZERO = 32'h0000_0000.
  - Default L = 7.
- Sub-module: reuse NOPPipeline (Stages=Pipeline_Stages) as the tag pipeline, with NOPIn = ~issue_valid and ret = ~NOPOut.
- All remaining logic lives in fp_acc_sched.

Test Plan:
- Single input (bench adder model, L=7): cfg_len=1, DataIn=0x3FC00000 (1.5) at cycle 0 -> DataOutValid at cycle 8, DataOut=0x3FC00000, busy low after.
- Short group: cfg_len=4, back-to-back 1.0, 2.0, 3.0, 4.0 -> a single DataOutValid, DataOut=0x41200000 (10.0); in_ready=0 from the cycle after the 4th accept until IDLE.
- Long group: cfg_len=16, sixteen back-to-back 1.0 (0x3F800000) -> DataOut=0x41800000 (16.0); live never exceeds 7; emit within 30 cycles of the last accept.
- Gappy input: cfg_len=8, 2.0 with in_valid toggling 1/0 -> DataOut=0x41800000 (16.0); exactly one pulse.
- Back-to-back groups: two groups, cfg_len=3 then 5, all 1.0 -> pulses carrying 0x40400000 (3.0) then 0x40A00000 (5.0); cfg_len changed mid-group has no effect.
- Reset mid-REDUCE: assert rst during the reduction of a cfg_len=16 group -> no pulse; in_ready=1 the cycle after release; the next group of 4×1.0 gives 0x40800000.
